// File: rtl/pingpong_bank_writer.sv
// rtl/pingpong_bank_writer.sv - packs a word stream into frames alternating between two buffer banks
// Optional stall-pressure counter is built only when PINGPONG_OVERRUN_CNT_EN is defined.
module pingpong_bank_writer #(
   parameter int WORD_SIZE   = 16,
   parameter int FRAME_WORDS = 784,
   parameter int ADDR_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [WORD_SIZE-1:0]  in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WORD_SIZE-1:0]  data_out,
   output logic                  sel,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  wr_en_0,
   output logic                  wr_en_1,
   output logic [1:0]            bank_full,
   input  logic [1:0]            bank_release,
   output logic                  frame_done,
   output logic                  frame_bank,
   output logic [15:0]           overrun_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

   logic                  fill_bank;
   logic [ADDR_WIDTH-1:0] count;
   logic [1:0]            full;
   logic                  accept;
   logic                  last_word;
   logic [1:0]            done_mask;
   logic [1:0]            full_next;

   // Ready is withheld during reset and whenever the bank being filled still holds an unread frame.
   assign in_ready  = reset_n & ~full[fill_bank];
   assign accept    = in_valid & in_ready;
   assign last_word = accept && (count == LAST_ADDR);
   assign done_mask = last_word ? (fill_bank ? 2'b10 : 2'b01) : 2'b00;

   // A release only clears a flag that is already set, and never the bank completing this cycle.
   assign full_next = (full & ~(bank_release & full & ~done_mask)) | done_mask;

   assign bank_full = full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_bank  <= 1'b0;
         count      <= '0;
         full       <= 2'b00;
         data_out   <= '0;
         sel        <= 1'b0;
         wr_addr    <= '0;
         wr_en_0    <= 1'b0;
         wr_en_1    <= 1'b0;
         frame_done <= 1'b0;
         frame_bank <= 1'b0;
      end else begin
         full       <= full_next;
         wr_en_0    <= accept & ~fill_bank;
         wr_en_1    <= accept & fill_bank;
         data_out   <= accept ? in_data : '0;
         frame_done <= last_word;
         if (accept) begin
            sel     <= fill_bank;
            wr_addr <= count;
            if (last_word) begin
               count      <= '0;
               fill_bank  <= ~fill_bank;
               frame_bank <= fill_bank;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

`ifdef PINGPONG_OVERRUN_CNT_EN
   logic [15:0] overrun_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_cnt <= '0;
      end else if (in_valid && !in_ready && overrun_cnt != 16'hFFFF) begin
         overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

   assign overrun_count = overrun_cnt;
`else
   assign overrun_count = 16'h0000;
`endif

endmodule

// File: doc/pingpong_bank_writer.md
# pingpong_bank_writer

Upstream stage of the two-way word demultiplexer in the digit-recognition datapath. Accepts a valid/ready pixel stream from the Avalon input path. Packs the stream into fixed-size frames (one 28x28 image by default) and alternates frames between two buffer banks. Drives the demux `data_in`/`sel` pair plus per-bank write address and enables, so that one bank fills while the inference engine reads the other.

## Interface
- `WORD_SIZE`, 16: width of one pixel/word; matches the demux word size.
- `FRAME_WORDS`, 784: words per frame; legal range 2 to 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 10: bank address width.

- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `WORD_SIZE`  incoming word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `data_out`  out  `WORD_SIZE`  word to demux `data_in`.
- `sel`  out  1  bank of the word on `data_out`; to demux `sel`.
- `wr_addr`  out  `ADDR_WIDTH`  write address within the selected bank.
- `wr_en_0`, `wr_en_1`  out  1 each  per-bank write strobe.
- `bank_full`  out  2  bit i = bank i holds a complete, unconsumed frame.
- `bank_release`  in  2  bit i pulse = consumer finished with bank i.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `frame_bank`  out  1  bank just completed; valid with `frame_done`.
- `overrun_count`  out  16  stall-pressure counter (see Configuration).

## Operation
- Internal state:
  - `fill_bank` (1 bit): bank currently being filled.
  - `count` (`ADDR_WIDTH` bits): next write address.
  - `full[1:0]`: per-bank full flags.
- The controller has two effective states:
  - FILL: `full[fill_bank]`=0. `in_ready`=1.
  - STALL: `full[fill_bank]`=1. `in_ready`=0.
- `in_ready` is combinational from `full[fill_bank]` and is 0 while `reset_n`=0.
- Accept occurs when `in_valid && in_ready`. On accept:
  - Register `data_out` <= `in_data`, `sel` <= `fill_bank`, `wr_addr` <= `count`.
  - Assert `wr_en_<fill_bank>` for exactly one cycle.
- On accept with `count` = `FRAME_WORDS`-1:
  - `count` <= 0 and `full[fill_bank]` <= 1.
  - `frame_done` <= 1 and `frame_bank` <= `fill_bank`.
  - `fill_bank` toggles.
- On any other accept: `count` increments by 1. No wrap occurs below `FRAME_WORDS`.
- Cycles with no accept:
  - Both `wr_en` are 0 and `data_out` = 0.
  - `sel` and `wr_addr` hold their last values.
- `bank_release[i]` clears `full[i]` only if `full[i]` is already 1. A release of a non-full bank is ignored.
- Release and completion of the same bank in the same cycle: the release is ignored and `full` = 1 results.
- Releasing the stalled bank returns to FILL on the next cycle. The first word is accepted at `count` 0.
- Releases of both banks in the same cycle are both honoured.
- `bank_full` = `full`. It updates on the edge after completion or release.
- Reset mid-frame discards the partial frame and clears both full flags.

## Timing
- Reset values: `in_ready` 0 during reset, 1 on the first cycle after release. All other outputs are 0: `data_out`, `sel`, `wr_addr`, `wr_en_0`, `wr_en_1`, `bank_full`, `frame_done`, `frame_bank`, `overrun_count`.
- Latency is 1 cycle: accept at edge N produces `wr_en`/`data_out`/`sel`/`wr_addr` during cycle N+1.
- Sustained throughput is 1 word/cycle, including back-to-back across a frame boundary into an empty bank.
- `frame_done` is coincident with the final word's `wr_en`.
- `in_ready` falls in the cycle after the last word of a frame if the next bank is full.
- Release-to-ready latency is 1 cycle.

## Configuration
- `PINGPONG_OVERRUN_CNT_EN` defined: `overrun_count` increments each cycle `in_valid`=1 and `in_ready`=0.
  - The counter saturates at 16'hFFFF.
  - It clears only on reset.
- `PINGPONG_OVERRUN_CNT_EN` undefined: no counter logic is built and `overrun_count` is tied to 0.

## Test plan
All scenarios use `FRAME_WORDS`=4, `ADDR_WIDTH`=2.
- Reset, then stream 4 words 0x11..0x14 with `in_valid` high continuously:
  - `wr_en_0` high for 4 cycles at addresses 0..3, `sel`=0.
  - `frame_done`=1 with `frame_bank`=0 on the 4th write.
  - `bank_full`=2'b01.
- Stream 12 words with no releases:
  - Bank 0 then bank 1 fill and `bank_full`=2'b11.
  - `in_ready`=0 after word 8; words 9..12 are held.
  - With the macro defined, `overrun_count` increases by 1 per stalled cycle.
- While stalled, pulse `bank_release`=2'b01:
  - `in_ready`=1 one cycle later.
  - Word 9 is written to bank 0 at address 0 with `sel`=0.
- Release bank 1 in the same cycle as the final word of bank 1: `bank_full[1]`=1 afterwards. Release of a non-full bank has no effect.
- Assert `reset_n`=0 after 2 words of a frame, then restream 4 words: all outputs return to 0 and the new words land in bank 0 at addresses 0..3.
- Drive `in_valid` high on alternate cycles only: `count` advances only on accepts, and `data_out`=0 with both `wr_en` low on idle cycles.
